btn_event_reader: RTL and testbench

//  Input-side counterpart of the board LED drivers: samples N raw push-button/switch lines,

---
 rtl/btn_event_if.sv | 14 +
 rtl/btn_event_reader.sv | 140 ++++++++++++++
 tb/tb_btn_event_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_if.sv
// Event handshake between the button reader (master) and its consumer (slave).
interface btn_event_if #(
    parameter int N = 16
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          ev_valid;
    logic          ev_ready;
    logic          ev_press;
    logic [IW-1:0] ev_index;

    modport master (output ev_valid, ev_press, ev_index, input ev_ready);
    modport slave  (input ev_valid, ev_press, ev_index, output ev_ready);
endinterface

// File: rtl/btn_event_reader.sv
// Synchronises and debounces N button lines on a slow tick and queues each accepted
// press/release as an {press, index} event behind a valid/ready handshake.
module btn_event_reader #(
    parameter int N            = 16,
    parameter int TICK_CYCLES  = 5000000,
    parameter int STABLE_TICKS = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_state,
    output logic         overflow,
    input  logic         ovf_clr,
    btn_event_if.master  ev
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TICK_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N-1:0]            sync1, sync2;
    logic [CW-1:0]           tick_cnt;
    logic                    tick;
    logic [STABLE_TICKS-1:0] hist      [N];
    logic [STABLE_TICKS-1:0] hist_next [N];
    logic [N-1:0]            edge_v, edge_kind;
    logic [N-1:0]            pend_v, pend_kind;
    logic [N-1:0]            grant, loss;
    logic [IW-1:0]           grant_idx;
    logic                    push, pop, can_push, fifo_valid;
    logic [IW:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;

    assign tick       = (tick_cnt == CW'(TICK_CYCLES - 1));
    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid & ev.ev_ready;
    assign can_push   = (count != (AW+1)'(FIFO_DEPTH)) || pop;

    assign ev.ev_valid = fifo_valid;
    assign ev.ev_press = mem[rd_ptr][IW];
    assign ev.ev_index = mem[rd_ptr][IW-1:0];

    // Newest sample enters at bit 0; the size cast drops the oldest one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hist_next[i] = STABLE_TICKS'({hist[i], sync2[i]});
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        push      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_v[i] && !push && can_push) begin
                push      = 1'b1;
                grant_idx = IW'(i);
                grant[i]  = 1'b1;
            end
        end
        loss = edge_v & pend_v & ~grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            tick_cnt  <= '0;
            btn_state <= '0;
            edge_v    <= '0;
            edge_kind <= '0;
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            edge_v   <= '0;
            if (tick) begin
                for (int i = 0; i < N; i++) begin
                    hist[i] <= hist_next[i];
                    if ((hist_next[i] == '0 || &hist_next[i]) && hist_next[i][0] != btn_state[i]) begin
                        btn_state[i] <= hist_next[i][0];
                        edge_v[i]    <= 1'b1;
                        edge_kind[i] <= hist_next[i][0];
                    end
                end
            end
        end
    end

    // A fresh edge replaces the slot even when it is granted, since the old kind leaves this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v    <= '0;
            pend_kind <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (edge_v[i]) begin
                    pend_v[i]    <= 1'b1;
                    pend_kind[i] <= edge_kind[i];
                end else if (grant[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
            if (|loss) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pend_kind[grant_idx], grant_idx};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_event_reader.sv
// Directed bench for btn_event_reader: expected events go into a scoreboard queue and a
// monitor compares them against every accepted handshake.
module tb_btn_event_reader;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic          press;
        logic [IW-1:0] index;
    } ev_t;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_state;
    logic         overflow;
    logic         ovf_clr = 1'b0;

    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    btn_event_if #(.N(N)) ev ();

    btn_event_reader #(
        .N(N), .TICK_CYCLES(4), .STABLE_TICKS(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_state(btn_state),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .ev(ev)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] raw, input logic ready);
        btn_raw     = raw;
        ev.ev_ready = ready;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitState(input int b, input logic val, input string name);
        for (int k = 0; k < 24 && btn_state[b] !== val; k++) stepCycles(1);
        checkOutput(name, 32'(btn_state[b]), 32'(val));
    endtask

    task automatic drain(input string name);
        ev.ev_ready = 1'b1;
        for (int k = 0; k < 40 && (ev.ev_valid || exp_q.size() != 0); k++) stepCycles(1);
        checkOutput({name, "_left"}, 32'(exp_q.size()), 32'd0);
        checkOutput({name, "_valid"}, 32'(ev.ev_valid), 32'd0);
        ev.ev_ready = 1'b0;
    endtask

    task automatic toggle0(input logic v);
        applyStimulus({3'b000, v}, 1'b0);
        waitState(0, v, "t5_toggle");
        stepCycles(4);
    endtask

    // Every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && ev.ev_valid && ev.ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL mon_unexpected actual=%0b/%0d expected=none", ev.ev_press, ev.ev_index);
            end else begin
                checkOutput("mon_event", 32'({ev.ev_press, ev.ev_index}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ev.ev_ready = 1'b0;
        stepCycles(3);
        rst = 1'b0;

        // 1: idle after reset
        for (int k = 0; k < 4; k++) begin
            stepCycles(10);
            checkOutput("t1_state", 32'(btn_state), 32'd0);
            checkOutput("t1_valid", 32'(ev.ev_valid), 32'd0);
            checkOutput("t1_ovf", 32'(overflow), 32'd0);
        end

        // 2: single press/release with exact state-to-valid latency
        exp_q.push_back('{press: 1'b1, index: 2'd2});
        applyStimulus(4'b0100, 1'b0);
        waitState(2, 1'b1, "t2_state");
        stepCycles(1);
        checkOutput("t2_valid_early", 32'(ev.ev_valid), 32'd0);
        stepCycles(1);
        checkOutput("t2_valid", 32'(ev.ev_valid), 32'd1);
        checkOutput("t2_head", 32'({ev.ev_press, ev.ev_index}), 32'b110);
        applyStimulus(4'b0100, 1'b1);
        stepCycles(1);
        checkOutput("t2_valid_fall", 32'(ev.ev_valid), 32'd0);
        applyStimulus(4'b0100, 1'b0);
        exp_q.push_back('{press: 1'b0, index: 2'd2});
        applyStimulus(4'b0000, 1'b0);
        waitState(2, 1'b0, "t2_release");
        drain("t2_drain");

        // 3: glitch shorter than the stability window
        applyStimulus(4'b0010, 1'b0);
        stepCycles(6);
        applyStimulus(4'b0000, 1'b0);
        stepCycles(30);
        checkOutput("t3_state", 32'(btn_state), 32'd0);
        checkOutput("t3_valid", 32'(ev.ev_valid), 32'd0);

        // 4: simultaneous presses queue in index order
        exp_q.push_back('{press: 1'b1, index: 2'd0});
        exp_q.push_back('{press: 1'b1, index: 2'd1});
        exp_q.push_back('{press: 1'b1, index: 2'd3});
        applyStimulus(4'b1011, 1'b0);
        for (int k = 0; k < 24 && btn_state !== 4'b1011; k++) stepCycles(1);
        checkOutput("t4_state", 32'(btn_state), 32'b1011);
        stepCycles(5);
        checkOutput("t4_valid", 32'(ev.ev_valid), 32'd1);
        checkOutput("t4_head", 32'({ev.ev_press, ev.ev_index}), 32'(exp_q[0]));
        stepCycles(3);
        checkOutput("t4_head_stable", 32'({ev.ev_press, ev.ev_index}), 32'(exp_q[0]));
        drain("t4_drain");
        exp_q.push_back('{press: 1'b0, index: 2'd0});
        exp_q.push_back('{press: 1'b0, index: 2'd1});
        exp_q.push_back('{press: 1'b0, index: 2'd3});
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 24 && btn_state !== 4'b0000; k++) stepCycles(1);
        checkOutput("t4_release", 32'(btn_state), 32'd0);
        stepCycles(5);
        drain("t4_drain_rel");

        // 5: fill the queue, then overwrite the pending slot of button 0
        exp_q.push_back('{press: 1'b1, index: 2'd0});
        toggle0(1'b1);
        exp_q.push_back('{press: 1'b0, index: 2'd0});
        toggle0(1'b0);
        exp_q.push_back('{press: 1'b1, index: 2'd0});
        toggle0(1'b1);
        exp_q.push_back('{press: 1'b0, index: 2'd0});
        toggle0(1'b0);
        toggle0(1'b1);
        checkOutput("t5_ovf_before", 32'(overflow), 32'd0);
        exp_q.push_back('{press: 1'b0, index: 2'd0});
        toggle0(1'b0);
        checkOutput("t5_ovf_set", 32'(overflow), 32'd1);
        stepCycles(5);
        checkOutput("t5_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        stepCycles(1);
        ovf_clr = 1'b0;
        checkOutput("t5_ovf_clr", 32'(overflow), 32'd0);
        stepCycles(3);
        checkOutput("t5_ovf_stays", 32'(overflow), 32'd0);
        drain("t5_drain");

        // 6: asynchronous reset with a queued event and histories mid-count
        applyStimulus(4'b1000, 1'b0);
        waitState(3, 1'b1, "t6_state");
        stepCycles(3);
        checkOutput("t6_valid_pre", 32'(ev.ev_valid), 32'd1);
        applyStimulus(4'b1010, 1'b0);
        stepCycles(6);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_state", 32'(btn_state), 32'd0);
        checkOutput("t6_rst_valid", 32'(ev.ev_valid), 32'd0);
        checkOutput("t6_rst_head", 32'({ev.ev_press, ev.ev_index}), 32'd0);
        checkOutput("t6_rst_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        applyStimulus(4'b1000, 1'b0);
        stepCycles(3);
        rst = 1'b0;
        exp_q.push_back('{press: 1'b1, index: 2'd3});
        waitState(3, 1'b1, "t6_again");
        drain("t6_drain");
        ev.ev_ready = 1'b1;
        stepCycles(20);
        checkOutput("t6_quiet", 32'(ev.ev_valid), 32'd0);
        checkOutput("t6_final_state", 32'(btn_state), 32'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
